imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a program load.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-005 SHALL have port in_data, input, 8 bits: program byte, high byte of each word first.
REQ-006 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-007 SHALL have port rd_addr, input, 4 bits: fetch address from the CPU.
REQ-008 SHALL have port rd_data, output, 16 bits: instruction at rd_addr.
REQ-009 SHALL have port busy, output, 1 bit: load in progress, hold the CPU.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the load completes.
REQ-011 SHALL have port err, output, 1 bit: the last load held 16 words with no HALT.
REQ-012 SHALL have port load_count, output, 5 bits: words received in the last load (0-16).

Function
REQ-013 SHALL store 16 words x 16 bits; unused slots read 16'h0000 (NOP).
REQ-014 SHALL treat a word with [15:12]=4'b1111 as HALT.
REQ-015 SHALL implement five states: IDLE, HI, LO, FILL, DONE.
REQ-016 SHALL, in IDLE or DONE, on start=1: go to HI; set waddr=0, load_count=0, err=0.
REQ-017 SHALL ignore start in HI, LO and FILL.
REQ-018 SHALL drive in_ready=1 only in HI and LO.
REQ-019 SHALL transfer a byte only on the edge where in_valid=1 and in_ready=1.
REQ-020 SHALL, with no transfer, hold state and data for any number of idle cycles.
REQ-021 SHALL, on a transfer in HI: latch the high byte and go to LO.
REQ-022 SHALL, on a transfer in LO: write {hi, in_data} to mem[waddr] on that edge and increment load_count.
REQ-023 SHALL, after the LO write, select the next state as follows.
 - waddr=15: go to DONE; set err=1 if the word is not HALT.
 - word is HALT and waddr<15: waddr+1, go to FILL.
 - otherwise: waddr+1, go to HI.
REQ-024 SHALL, in FILL, write 0 to mem[waddr] each cycle.
 - waddr<15: waddr+1, stay in FILL.
 - waddr=15: go to DONE.
REQ-025 SHALL hold DONE for exactly one cycle with done=1, then go to IDLE, unless start=1 (REQ-016).
REQ-026 SHALL drive busy=1 in HI, LO and FILL, and 0 otherwise.
REQ-027 SHALL make rd_data combinational.
 - busy=1: 16'h0000.
 - busy=0: mem[rd_addr].
REQ-028 SHALL hold err and load_count until the next accepted start.
REQ-029 SHALL limit load latency to 2 accepted bytes per word; FILL adds (15 - halt_addr) cycles; DONE adds 1 cycle.

Reset
REQ-030 SHALL, on rst=1, asynchronously set:
 - state=IDLE, all 16 words=0, waddr=0, hi=0;
 - load_count=0, err=0, done=0, busy=0, in_ready=0.
REQ-031 SHALL, if rst asserts mid-load, discard the partial load, so memory reads all zeros after release.
REQ-032 SHALL leave IDLE no earlier than the first rising clk edge after rst deasserts.

Structure
REQ-033 SHALL take the following from a shared package:
 - OP_HALT=4'b1111, NOP_WORD=16'h0000;
 - IMEM_DEPTH=16, IMEM_AW=4;
 - the loader state enum.
REQ-034 SHALL place the storage in a sub-module, imem_regfile: 16x16, one synchronous write port, one asynchronous read port, asynchronous clear.

Verification
REQ-035 SHALL cover a full load.
 - Stimulus: start, then bytes 00 00, 10 F5, 50 00, 80 00, 90 0A, B0 02, F0 00 with in_valid held high.
 - Response: FILL writes addresses 7-15 in 9 cycles, then done pulses once; mem[1]=10F5, mem[6]=F000, mem[7..15]=0000; load_count=7, err=0.
REQ-036 SHALL cover backpressure.
 - Stimulus: the same program with 0-3 random idle cycles between bytes.
 - Response: identical memory contents; in_ready never drops in HI or LO.
REQ-037 SHALL cover overflow.
 - Stimulus: 16 words of 16'h1001.
 - Response: no FILL; done pulses; err=1, load_count=16; all words=1001.
REQ-038 SHALL cover reset mid-load.
 - Stimulus: rst asserted while in LO after 3 words.
 - Response: busy=0 at once; all rd_data=0000; the next start/load behaves as REQ-035.
REQ-039 SHALL cover start while busy and reads during a load.
 - Stimulus: start pulsed during HI; rd_addr=1 sampled during the load.
 - Response: no restart; rd_data=0000 while busy=1 and 10F5 after done.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory loader.
package imem_loader_pkg;

  localparam logic [3:0]  OP_HALT    = 4'b1111;
  localparam logic [15:0] NOP_WORD   = 16'h0000;
  localparam int unsigned IMEM_DEPTH = 16;
  localparam int unsigned IMEM_AW    = 4;
  localparam int unsigned IMEM_DW    = 16;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    FILL,
    DONE
  } state_t;

  function automatic logic is_halt(input logic [IMEM_DW-1:0] word);
    return word[IMEM_DW-1:IMEM_DW-4] == OP_HALT;
  endfunction

endpackage

// File: rtl/imem_regfile.sv
// 16x16 program store: one synchronous write port, one asynchronous read port, async clear.
module imem_regfile
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IMEM_AW-1:0] waddr,
  input  logic [IMEM_DW-1:0] wdata,
  input  logic [IMEM_AW-1:0] raddr,
  output logic [IMEM_DW-1:0] rdata
);

  logic [IMEM_DW-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
        mem[i] <= NOP_WORD;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte-stream (high byte first) into instruction memory, padding
// with NOPs after a HALT word and holding the CPU off the fetch port while loading.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic [IMEM_AW-1:0] rd_addr,
  output logic [IMEM_DW-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   load_count
);

  localparam logic [IMEM_AW-1:0] LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);

  state_t             state;
  logic [IMEM_AW-1:0] waddr;
  logic [7:0]         hi;
  logic               xfer;
  logic [IMEM_DW-1:0] word;
  logic               we;
  logic [IMEM_DW-1:0] wdata;
  logic [IMEM_DW-1:0] mem_rdata;

  assign xfer = in_valid && in_ready;
  assign word = {hi, in_data};

  // Write port: the assembled word on a LO transfer, NOP padding in FILL.
  always_comb begin
    we    = 1'b0;
    wdata = NOP_WORD;
    if (state == LO && xfer) begin
      we    = 1'b1;
      wdata = word;
    end else if (state == FILL) begin
      we    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      waddr      <= '0;
      hi         <= '0;
      load_count <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state      <= HI;
            waddr      <= '0;
            load_count <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end
        end
        HI: begin
          if (xfer) begin
            hi    <= in_data;
            state <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            load_count <= load_count + CNT_W'(1);
            if (waddr == LAST_ADDR) begin
              state    <= DONE;
              err      <= !is_halt(word);
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (is_halt(word)) begin
              waddr    <= waddr + IMEM_AW'(1);
              state    <= FILL;
              in_ready <= 1'b0;
            end else begin
              waddr <= waddr + IMEM_AW'(1);
              state <= HI;
            end
          end
        end
        FILL: begin
          if (waddr == LAST_ADDR) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            waddr <= waddr + IMEM_AW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  imem_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // The CPU sees NOPs while a load is in progress.
  assign rd_data = busy ? NOP_WORD : mem_rdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven memory readback plus hand-written load sequences.
module tb_imem_loader;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  load_count;

  int   checks = 0;
  int   errors = 0;
  vec_t prog_vec [16];
  logic [7:0] prog_bytes [14];

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(in_ready), 32'd1);
  endtask

  // Offer one byte after 'gap' idle cycles; in_ready must stay high while idling in HI/LO.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      tick();
      check("ready_held", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic send_prog(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      send_byte(prog_bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic wait_done(input int exp_cycles);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("done_latency", 32'(n), 32'(exp_cycles));
    check("done_pulse", 32'(done), 32'd1);
    tick();
    check("done_single", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_prog_mem();
    for (int i = 0; i < 16; i++) begin
      rd_addr = prog_vec[i].addr;
      #1;
      check($sformatf("mem[%0d]", i), 32'(rd_data), 32'(prog_vec[i].exp));
    end
  endtask

  task automatic check_const_mem(input string name, input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s[%0d]", name, i), 32'(rd_data), 32'(v));
    end
  endtask

  task automatic full_load(input int max_gap);
    do_start();
    send_prog(0, 13, max_gap);
    in_valid = 1'b0;
    check("fill_busy", 32'(busy), 32'd1);
    check("fill_ready", 32'(in_ready), 32'd0);
    wait_done(9);
    check("full_count", 32'(load_count), 32'd7);
    check("full_err", 32'(err), 32'd0);
    check_prog_mem();
  endtask

  initial begin
    prog_bytes = '{8'h00, 8'h00, 8'h10, 8'hF5, 8'h50, 8'h00, 8'h80, 8'h00,
                   8'h90, 8'h0A, 8'hB0, 8'h02, 8'hF0, 8'h00};
    prog_vec[0] = '{4'd0, 16'h0000};
    prog_vec[1] = '{4'd1, 16'h10F5};
    prog_vec[2] = '{4'd2, 16'h5000};
    prog_vec[3] = '{4'd3, 16'h8000};
    prog_vec[4] = '{4'd4, 16'h900A};
    prog_vec[5] = '{4'd5, 16'hB002};
    prog_vec[6] = '{4'd6, 16'hF000};
    for (int i = 7; i < 16; i++) prog_vec[i] = '{4'(i), 16'h0000};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_addr = 4'd0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_const_mem("rst_mem", 16'h0000);

    // Full load with in_valid held high.
    full_load(0);

    // Same program with 0-3 idle cycles between bytes.
    full_load(3);

    // Overflow: 16 non-HALT words, goes straight to DONE.
    do_start();
    for (int w = 0; w < 16; w++) begin
      send_byte(8'h10, 0);
      send_byte(8'h01, 0);
    end
    in_valid = 1'b0;
    check("ovf_done_now", 32'(done), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_count", 32'(load_count), 32'd16);
    tick();
    check("ovf_done_single", 32'(done), 32'd0);
    repeat (3) tick();
    check("ovf_err_held", 32'(err), 32'd1);
    check_const_mem("ovf_mem", 16'h1001);

    // Reload over the overflow image: FILL must clear 7..15.
    full_load(0);

    // Start pulsed during HI is ignored; fetch port reads NOP while busy.
    do_start();
    send_prog(0, 1, 0);
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nostart_count", 32'(load_count), 32'd1);
    check("nostart_busy", 32'(busy), 32'd1);
    send_prog(2, 3, 0);
    in_valid = 1'b0;
    rd_addr = 4'd1;
    #1;
    check("busy_rd", 32'(rd_data), 32'h0000);
    send_prog(4, 13, 0);
    in_valid = 1'b0;
    wait_done(9);
    check("nostart_final_count", 32'(load_count), 32'd7);
    rd_addr = 4'd1;
    #1;
    check("after_done_rd", 32'(rd_data), 32'h10F5);
    check_prog_mem();

    // Reset in LO after three words.
    do_start();
    send_prog(0, 6, 0);
    in_valid = 1'b0;
    check("mid_ready", 32'(in_ready), 32'd1);
    check("mid_count", 32'(load_count), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_rst_count", 32'(load_count), 32'd0);
    check_const_mem("mid_rst_mem", 16'h0000);
    full_load(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
